// File: rtl/pick_sched_pkg.sv
// Shared types, widths and sizing helpers for the vision-guided pick scheduler.
package pick_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEARCH    = 3'd1,
        S_CONFIRM   = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_SETTLE    = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam int COORD_W = 9;
    localparam int SHAPE_W = 3;
    localparam int COLOR_W = 2;

    // Bits needed for a counter running 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pick_confirm_filter.sv
// Detection filter: latches a candidate target and counts consecutive
// detections that agree with it within a per-axis tolerance and on shape.
module pick_confirm_filter
    import pick_sched_pkg::*;
#(
    parameter int CONFIRM_N = 3,
    parameter int POS_TOL   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               sample_vld,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [SHAPE_W-1:0] shape_in,
    output logic               confirmed,
    output logic [COORD_W-1:0] x_o,
    output logic [SHAPE_W-1:0] shape_o,
    output logic [COORD_W-1:0] y_o
);
    localparam int CW = cnt_w(CONFIRM_N + 1);
    localparam logic signed [COORD_W:0] TOL_P = (COORD_W + 1)'(POS_TOL);
    localparam logic signed [COORD_W:0] TOL_N = -TOL_P;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [SHAPE_W-1:0] shape_q, shape_d;
    logic signed [COORD_W:0] dx, dy;
    logic               consistent;

    // Tolerance compare and next latched candidate / agreement count.
    always_comb begin
        dx         = $signed({1'b0, x_in}) - $signed({1'b0, x_q});
        dy         = $signed({1'b0, y_in}) - $signed({1'b0, y_q});
        consistent = (dx <= TOL_P) && (dx >= TOL_N) &&
                     (dy <= TOL_P) && (dy >= TOL_N) &&
                     (shape_in == shape_q);
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        shape_d = shape_q;
        if (sample_vld) begin
            if ((cnt_q == '0) || !consistent) begin
                x_d     = x_in;
                y_d     = y_in;
                shape_d = shape_in;
                cnt_d   = CW'(1);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clear) begin
            cnt_d = '0;
        end
        // Next-state payload is exported so a confirming sample that also
        // re-latches (CONFIRM_N == 1) still hands over its own coordinates.
        confirmed = sample_vld && (cnt_d == CW'(CONFIRM_N));
        x_o       = x_d;
        y_o       = y_d;
        shape_o   = shape_d;
    end

    // Candidate and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            shape_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            shape_q <= shape_d;
        end
    end

endmodule

// File: rtl/pick_scheduler.sv
// Pick-loop sequencer: colour sweep, target confirmation, req/ack pick
// command issue, pick counting and post-pick settle delay.
module pick_scheduler
    import pick_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int CONFIRM_N   = 3,
    parameter int POS_TOL     = 4,
    parameter int SETTLE_CYC  = 25_000_000,
    parameter int MAX_TARGETS = 6,
    parameter int NUM_COLORS  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               detect_finish,
    input  logic               target_is_invalid,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [SHAPE_W-1:0] shape_in,
    input  logic               sel_a_b,
    input  logic               pick_ack,
    input  logic               pick_done,
    output logic [COLOR_W-1:0] color_sel,
    output logic               pick_req,
    output logic [COORD_W-1:0] pick_x,
    output logic [COORD_W-1:0] pick_y,
    output logic [SHAPE_W-1:0] pick_shape,
    output logic               pick_dest,
    output logic [2:0]         target_cnt,
    output logic               busy,
    output logic               all_done
);
    localparam int TO_W = cnt_w(TIMEOUT_CYC);
    localparam int ST_W = cnt_w(SETTLE_CYC);
    localparam int SW_W = cnt_w(NUM_COLORS + 1);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [ST_W-1:0]    ST_LAST  = ST_W'(SETTLE_CYC - 1);
    localparam logic [SW_W-1:0]    SW_END   = SW_W'(NUM_COLORS);
    localparam logic [COLOR_W-1:0] COL_LAST = COLOR_W'(NUM_COLORS - 1);
    localparam logic [2:0]         TGT_END  = 3'(MAX_TARGETS);

    state_t             state_q, state_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [SW_W-1:0]    sweep_q, sweep_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [ST_W-1:0]    settle_q, settle_d;
    logic [2:0]         tcnt_q, tcnt_d;
    logic               req_q, req_d, dest_q, dest_d, busy_q, done_q;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic [SHAPE_W-1:0] ps_q, ps_d;

    logic               searching, samp_vld, filt_clr, timeout, complete, confirmed;
    logic [COORD_W-1:0] fx, fy;
    logic [SHAPE_W-1:0] fs;

    assign searching = (state_q == S_SEARCH) || (state_q == S_CONFIRM);
    assign samp_vld  = searching && detect_finish && !target_is_invalid;
    assign filt_clr  = !searching || timeout;

    pick_confirm_filter #(
        .CONFIRM_N (CONFIRM_N),
        .POS_TOL   (POS_TOL)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .clear      (filt_clr),
        .sample_vld (samp_vld),
        .x_in       (x_in),
        .y_in       (y_in),
        .shape_in   (shape_in),
        .confirmed  (confirmed),
        .x_o        (fx),
        .shape_o    (fs),
        .y_o        (fy)
    );

    // Next-state, timers, handshake and pick bookkeeping.
    always_comb begin
        state_d  = state_q;
        color_d  = color_q;
        sweep_d  = sweep_q;
        to_cnt_d = '0;
        settle_d = '0;
        tcnt_d   = tcnt_q;
        req_d    = req_q;
        px_d     = px_q;
        py_d     = py_q;
        ps_d     = ps_q;
        dest_d   = dest_q;
        timeout  = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                color_d = '0;
                sweep_d = '0;
                tcnt_d  = '0;
                if (start) state_d = S_SEARCH;
            end
            S_SEARCH, S_CONFIRM: begin
                if (target_is_invalid) begin
                    if (to_cnt_q == TO_LAST) begin
                        timeout = 1'b1;
                        color_d = (color_q == COL_LAST) ? '0 : color_q + 1'b1;
                        sweep_d = sweep_q + 1'b1;
                        state_d = (sweep_d == SW_END) ? S_DONE : S_SEARCH;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else if (confirmed) begin
                    state_d = S_ISSUE;
                    req_d   = 1'b1;
                    px_d    = fx;
                    py_d    = fy;
                    ps_d    = fs;
                    dest_d  = sel_a_b;
                end else if (samp_vld) begin
                    state_d = S_CONFIRM;
                end
            end
            S_ISSUE: begin
                if (pick_ack) begin
                    req_d = 1'b0;
                    if (pick_done) complete = 1'b1;
                    else           state_d  = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (pick_done) complete = 1'b1;
            end
            S_SETTLE: begin
                if (settle_q == ST_LAST) state_d  = S_SEARCH;
                else                     settle_d = settle_q + 1'b1;
            end
            S_DONE: begin
                if (start) begin
                    color_d = '0;
                    sweep_d = '0;
                    tcnt_d  = '0;
                    state_d = S_SEARCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (complete) begin
            tcnt_d  = (tcnt_q == 3'd7) ? tcnt_q : tcnt_q + 1'b1;
            sweep_d = '0;
            state_d = (tcnt_d == TGT_END) ? S_DONE : S_SETTLE;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            color_q  <= '0;
            sweep_q  <= '0;
            to_cnt_q <= '0;
            settle_q <= '0;
            tcnt_q   <= '0;
            req_q    <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            ps_q     <= '0;
            dest_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            color_q  <= color_d;
            sweep_q  <= sweep_d;
            to_cnt_q <= to_cnt_d;
            settle_q <= settle_d;
            tcnt_q   <= tcnt_d;
            req_q    <= req_d;
            px_q     <= px_d;
            py_q     <= py_d;
            ps_q     <= ps_d;
            dest_q   <= dest_d;
            busy_q   <= !((state_d == S_IDLE) || (state_d == S_DONE));
            done_q   <= (state_d == S_DONE);
        end
    end

    assign color_sel  = color_q;
    assign pick_req   = req_q;
    assign pick_x     = px_q;
    assign pick_y     = py_q;
    assign pick_shape = ps_q;
    assign pick_dest  = dest_q;
    assign target_cnt = tcnt_q;
    assign busy       = busy_q;
    assign all_done   = done_q;

endmodule

// File: tb/tb_pick_scheduler.sv
// Directed bench for pick_scheduler with short timeout/settle periods.
module tb_pick_scheduler;
    import pick_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, detect_finish, target_is_invalid, sel_a_b, pick_ack, pick_done;
    logic [8:0] x_in, y_in, pick_x, pick_y;
    logic [2:0] shape_in, pick_shape, target_cnt;
    logic [1:0] color_sel;
    logic       pick_req, pick_dest, busy, all_done;

    int checks = 0;
    int errors = 0;

    pick_scheduler #(
        .TIMEOUT_CYC (20),
        .CONFIRM_N   (3),
        .POS_TOL     (4),
        .SETTLE_CYC  (10),
        .MAX_TARGETS (6),
        .NUM_COLORS  (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .detect_finish     (detect_finish),
        .target_is_invalid (target_is_invalid),
        .x_in              (x_in),
        .y_in              (y_in),
        .shape_in          (shape_in),
        .sel_a_b           (sel_a_b),
        .pick_ack          (pick_ack),
        .pick_done         (pick_done),
        .color_sel         (color_sel),
        .pick_req          (pick_req),
        .pick_x            (pick_x),
        .pick_y            (pick_y),
        .pick_shape        (pick_shape),
        .pick_dest         (pick_dest),
        .target_cnt        (target_cnt),
        .busy              (busy),
        .all_done          (all_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic detect(input int x, input int y, input int s);
        detect_finish = 1'b1;
        x_in          = 9'(x);
        y_in          = 9'(y);
        shape_in      = 3'(s);
        cyc(1);
        detect_finish = 1'b0;
    endtask

    task automatic wait_search(input string tag);
        int n = 0;
        while (dut.state_q != S_SEARCH && n < 30) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(dut.state_q), 32'(S_SEARCH));
    endtask

    task automatic full_pick(input int x);
        wait_search("pick_wait_search");
        detect(x, 20, 1);
        detect(x, 20, 1);
        detect(x, 20, 1);
        chk("pick_req_up", 32'(pick_req), 32'd1);
        chk("pick_x_val", 32'(pick_x), 32'(x));
        pick_ack = 1'b1;
        cyc(1);
        pick_ack  = 1'b0;
        pick_done = 1'b1;
        cyc(1);
        pick_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; detect_finish = 1'b0; target_is_invalid = 1'b0;
        sel_a_b = 1'b0; pick_ack = 1'b0; pick_done = 1'b0;
        x_in = '0; y_in = '0; shape_in = '0;
        cyc(2);
        chk("rst_pick_req", 32'(pick_req), 32'd0);
        chk("rst_color", 32'(color_sel), 32'd0);
        chk("rst_target_cnt", 32'(target_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_all_done", 32'(all_done), 32'd0);
        chk("rst_pick_x", 32'(pick_x), 32'd0);
        rst = 1'b0;
        cyc(1);

        // Confirm and pick
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        sel_a_b = 1'b1;
        detect(100, 50, 2);
        chk("t1_req_after1", 32'(pick_req), 32'd0);
        detect(102, 48, 2);
        chk("t1_req_after2", 32'(pick_req), 32'd0);
        detect(101, 51, 2);
        chk("t1_req", 32'(pick_req), 32'd1);
        chk("t1_x", 32'(pick_x), 32'd100);
        chk("t1_y", 32'(pick_y), 32'd50);
        chk("t1_shape", 32'(pick_shape), 32'd2);
        chk("t1_dest", 32'(pick_dest), 32'd1);
        pick_ack = 1'b1;
        cyc(1);
        pick_ack = 1'b0;
        chk("t1_req_drop", 32'(pick_req), 32'd0);
        pick_done = 1'b1;
        cyc(1);
        pick_done = 1'b0;
        chk("t1_cnt", 32'(target_cnt), 32'd1);
        detect(100, 50, 2);
        cyc(8);
        chk("t1_settle_9", 32'(dut.state_q), 32'(S_SETTLE));
        cyc(1);
        chk("t1_search_10", 32'(dut.state_q), 32'(S_SEARCH));

        // Inconsistent sample re-latches
        sel_a_b = 1'b0;
        detect(100, 50, 2);
        detect(110, 50, 2);
        detect(111, 50, 2);
        chk("t2_req_after3", 32'(pick_req), 32'd0);
        detect(112, 50, 2);
        chk("t2_req", 32'(pick_req), 32'd1);
        chk("t2_x", 32'(pick_x), 32'd110);
        chk("t2_dest", 32'(pick_dest), 32'd0);

        // Payload holds while ack is delayed
        for (int i = 0; i < 7; i++) begin
            x_in = 9'(i * 37);
            cyc(1);
            chk("hold_req", 32'(pick_req), 32'd1);
            chk("hold_x", 32'(pick_x), 32'd110);
        end
        pick_ack = 1'b1;
        cyc(1);
        pick_ack = 1'b0;
        chk("hold_req_drop", 32'(pick_req), 32'd0);
        chk("hold_wait_state", 32'(dut.state_q), 32'(S_WAIT_DONE));
        pick_done = 1'b1;
        cyc(1);
        pick_done = 1'b0;
        chk("hold_cnt", 32'(target_cnt), 32'd2);

        // Ack and done in the same cycle
        wait_search("t3_wait_search");
        detect(200, 100, 5);
        detect(200, 100, 5);
        detect(200, 100, 5);
        chk("t3_req", 32'(pick_req), 32'd1);
        pick_ack  = 1'b1;
        pick_done = 1'b1;
        cyc(1);
        pick_ack  = 1'b0;
        pick_done = 1'b0;
        chk("t3_req_drop", 32'(pick_req), 32'd0);
        chk("t3_cnt", 32'(target_cnt), 32'd3);
        chk("t3_settle", 32'(dut.state_q), 32'(S_SETTLE));

        // Run end after six picks
        full_pick(30);
        full_pick(60);
        chk("t4_cnt5", 32'(target_cnt), 32'd5);
        chk("t4_busy5", 32'(busy), 32'd1);
        full_pick(90);
        chk("t4_cnt6", 32'(target_cnt), 32'd6);
        chk("t4_all_done", 32'(all_done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        pick_ack = 1'b1;
        cyc(2);
        pick_ack = 1'b0;
        chk("t4_ack_ignored", 32'(pick_req), 32'd0);
        pulse_start();
        chk("t4_restart_cnt", 32'(target_cnt), 32'd0);
        chk("t4_restart_done", 32'(all_done), 32'd0);

        // Colour sweep with no target
        target_is_invalid = 1'b1;
        cyc(19);
        chk("sw_color0", 32'(color_sel), 32'd0);
        cyc(1);
        chk("sw_color1", 32'(color_sel), 32'd1);
        cyc(19);
        chk("sw_color1b", 32'(color_sel), 32'd1);
        cyc(1);
        chk("sw_color2", 32'(color_sel), 32'd2);
        cyc(19);
        chk("sw_not_done", 32'(all_done), 32'd0);
        cyc(1);
        chk("sw_all_done", 32'(all_done), 32'd1);
        chk("sw_color_wrap", 32'(color_sel), 32'd0);
        chk("sw_busy", 32'(busy), 32'd0);
        target_is_invalid = 1'b0;

        // Reset during ISSUE
        pulse_start();
        detect(5, 6, 3);
        detect(5, 6, 3);
        detect(5, 6, 3);
        chk("r_req", 32'(pick_req), 32'd1);
        rst = 1'b1;
        cyc(1);
        chk("r_req_drop", 32'(pick_req), 32'd0);
        chk("r_cnt", 32'(target_cnt), 32'd0);
        chk("r_state", 32'(dut.state_q), 32'(S_IDLE));
        rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pick_scheduler.md
# pick_scheduler

Sequences the vision-guided pick loop between the image-processing pipeline and the robot-arm controller. It owns the colour-select output fed to `imag_process`, sweeps colours when no target is visible, and filters detection results until a stable target is confirmed. It then issues one pick command per target over a req/ack handshake and counts completed picks. It runs in the 50 MHz `clk` domain and replaces the free-running colour counter in `top`.

## Interface
Parameters:
- `TIMEOUT_CYC`, 100_000_000: cycles of continuous `target_is_invalid` (2 s) before the colour advances.
- `CONFIRM_N`, 3: consecutive consistent detections required to confirm a target.
- `POS_TOL`, 4: maximum per-axis coordinate difference for two detections to count as consistent.
- `SETTLE_CYC`, 25_000_000: cycles to wait after `pick_done` before searching again.
- `MAX_TARGETS`, 6: number of picks that ends a run.
- `NUM_COLORS`, 3: colour codes used are 0 to NUM_COLORS-1.

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; arms a run.
- `detect_finish` in 1: single-cycle pulse; a detection result is valid.
- `target_is_invalid` in 1: level; no target in the current frame.
- `x_in` in 9: target X coordinate, unsigned.
- `y_in` in 9: target Y coordinate, unsigned.
- `shape_in` in 3: target shape code.
- `sel_a_b` in 1: 1 = warehouse A, 0 = warehouse B; sampled at ISSUE entry.
- `pick_ack` in 1: robot has accepted the command.
- `pick_done` in 1: robot has finished the pick.
- `color_sel` out 2: colour code to `imag_process`.
- `pick_req` out 1: command valid.
- `pick_x` out 9: command payload.
- `pick_y` out 9: command payload.
- `pick_shape` out 3: command payload.
- `pick_dest` out 1: command payload.
- `target_cnt` out 3: completed picks.
- `busy` out 1: high in every state except IDLE and DONE.
- `all_done` out 1: high in DONE.

## Operation
States: IDLE, SEARCH, CONFIRM, ISSUE, WAIT_DONE, SETTLE, DONE.
- IDLE: `start` → SEARCH. `target_cnt`, `color_sel`, the sweep counter and the confirm counter clear.
- SEARCH / CONFIRM, target visible: `detect_finish` with `target_is_invalid`=0 is a valid sample. `detect_finish` with `target_is_invalid`=1 is ignored.
  - First valid sample: latch x, y and shape; `conf_cnt`=1; go to CONFIRM.
  - Later valid sample: consistent means |x−xl|≤POS_TOL, |y−yl|≤POS_TOL and equal shape. Differences are computed as 10-bit signed values. Consistent → `conf_cnt`+1. Inconsistent → re-latch the new sample; `conf_cnt`=1.
  - `conf_cnt` reaches CONFIRM_N → ISSUE.
- SEARCH / CONFIRM, timeout:
  - The timeout counter increments while `target_is_invalid`=1 and clears when it is 0.
  - At TIMEOUT_CYC-1: `color_sel` advances, wrapping NUM_COLORS-1→0. The timeout counter and `conf_cnt` clear; the state goes to SEARCH; the sweep counter increments.
  - Sweep counter reaching NUM_COLORS → DONE, meaning a full sweep found nothing.
- ISSUE: `pick_req`=1 with payload = latched x, y, shape and `sel_a_b`. The payload holds stable until `pick_ack`, then `pick_req` drops next cycle and the state goes to WAIT_DONE.
- WAIT_DONE: `pick_done` → `target_cnt`+1 (saturating); the sweep counter clears.
  - `target_cnt` equal to MAX_TARGETS → DONE.
  - Otherwise → SETTLE.
- SETTLE: counts SETTLE_CYC cycles, then goes to SEARCH with `conf_cnt`=0. Detections in SETTLE are ignored. `color_sel` is unchanged, so the same colour is retried first.
- DONE: `all_done`=1. `start` → IDLE-equivalent clear, then SEARCH.
- `start` outside IDLE and DONE is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - `color_sel`, `pick_x`, `pick_y`, `pick_shape`, `pick_dest` and `target_cnt` are 0.
  - `pick_req`, `busy` and `all_done` are 0.
- All outputs are registered.
- Latency:
  - `pick_req` rises the cycle after the CONFIRM_N-th consistent `detect_finish`.
  - `color_sel` changes the cycle after the timeout count hits TIMEOUT_CYC-1.
- `pick_ack` in the same cycle `pick_req` rises is accepted. `pick_ack` outside ISSUE is ignored.
- `pick_ack` and `pick_done` in the same cycle: the command is accepted and the pick completes, going straight to SETTLE or DONE. `pick_done` outside WAIT_DONE (and outside that case) is ignored.
- `rst` mid-handshake drops `pick_req` on the next edge with no pick counted.

## Structure
- `pick_sched_pkg`:
  - State enum.
  - Coordinate width (9), shape width (3) and colour width (2).
  - Counter width helper: $clog2 of TIMEOUT_CYC and SETTLE_CYC.
- Sub-module `pick_confirm_filter`:
  - Latches the sample and performs the tolerance compare and `conf_cnt`.
  - Inputs: sample and clear. Outputs: `confirmed` and the latched payload.
- The top FSM, timers and handshake stay in `pick_scheduler`.

## Test plan
Benches override TIMEOUT_CYC=20 and SETTLE_CYC=10.
- Confirm and pick: `start`, then 3 detections at (100,50,shape 2), (102,48,2), (101,51,2) → `pick_req` next cycle with x=100, y=50, shape=2, dest=`sel_a_b`. Ack, then done → `target_cnt`=1, SETTLE lasts 10 cycles, then SEARCH.
- Inconsistent reset: detections at (100,50), (110,50), (111,50), (112,50) → `pick_req` only after the 4th, with x=110.
- Colour sweep: `target_is_invalid` held high → `color_sel` steps 0→1→2 every 20 cycles. The third timeout gives DONE with `all_done`=1 and `color_sel`=0.
- Handshake hold: `pick_ack` delayed 7 cycles while `x_in` toggles → payload is constant and `pick_req` stays high exactly until the cycle after ack. Same-cycle ack and done → SETTLE.
- Run end: 6 full picks → DONE, `target_cnt`=6, `busy`=0. A further `start` clears `target_cnt` to 0.
- Reset in ISSUE → `pick_req`=0 next cycle; `target_cnt` is unchanged at 0; state is IDLE.
